// File: rtl/fetch_if.sv
// fetch_if: bundles the fetch controller's memory port, redirect port and
// decode handshake into one interface.
//
// master modport: the fetch controller (drives mem_re/mem_addr, ins_valid,
//   inscode, ins_pc and fetch_err; receives mem_rdata, br_taken, br_target
//   and ins_ready).
// slave modport: the environment, meaning the instruction memory, decode
//   and execute.
//
// Decode handshake: ins_valid/inscode/ins_pc are held stable while
// ins_valid=1 and ins_ready=0. An instruction transfers on a rising edge
// where ins_valid=1 and ins_ready=1. ins_valid never depends on ins_ready.
interface fetch_if #(
  parameter int AW = 5
) ();
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          br_taken;
  logic [31:0]   br_target;
  logic          ins_ready;
  logic          ins_valid;
  logic [31:0]   inscode;
  logic [31:0]   ins_pc;
  logic          fetch_err;

  modport master (
    output mem_re, mem_addr, ins_valid, inscode, ins_pc, fetch_err,
    input  mem_rdata, br_taken, br_target, ins_ready
  );

  modport slave (
    input  mem_re, mem_addr, ins_valid, inscode, ins_pc, fetch_err,
    output mem_rdata, br_taken, br_target, ins_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: reads four bytes from a byte-wide synchronous memory and
// assembles them into a little-endian 32-bit instruction for decode. It owns
// the PC, advances it by 4 on each decode handshake, and takes branch
// redirects from execute. If the PC is ever loaded with an illegal value,
// the controller locks into ERR until reset.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   bus          fetch_if.master (memory read, redirect, decode handshake)
//   dbg_state_o  current FSM state (IDLE=0, RD=1, LAST=2, VALID=3, ERR=4)
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_DEPTH = 32,
  parameter int          AW        = 5
) (
  input  logic       clk,
  input  logic       rst,
  fetch_if.master    bus,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_LAST  = 3'd2,
    S_VALID = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  localparam logic [31:0] LAST_PC = 32'(MEM_DEPTH - 4);

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d, cnt_nxt;
  logic [31:0]   pc_q, pc_d;
  logic [23:0]   buf_q, buf_d;     // bytes 0..2 of the fetch in progress
  logic          mem_re_q, mem_re_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          ins_valid_q, ins_valid_d;
  logic [31:0]   inscode_q, inscode_d;
  logic [31:0]   ins_pc_q, ins_pc_d;
  logic          fetch_err_q, fetch_err_d;
  logic          load_en;
  logic [31:0]   load_pc;

  function automatic logic pc_legal(input logic [31:0] p);
    return (p[1:0] == 2'b00) && (p <= LAST_PC);
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    ins_valid_d = 1'b0;
    inscode_d   = inscode_q;
    ins_pc_d    = ins_pc_q;
    fetch_err_d = fetch_err_q;
    load_en     = 1'b0;
    load_pc     = pc_q;
    cnt_nxt     = cnt_q + 2'd1;

    case (state_q)
      S_IDLE: begin
        state_d    = S_RD;
        cnt_d      = 2'd0;
        mem_re_d   = 1'b1;
        mem_addr_d = pc_q[AW-1:0];
      end
      S_RD: begin
        // Read data lags the address by one cycle, so in the cycle with
        // count cnt the data on mem_rdata belongs to byte cnt-1.
        case (cnt_q)
          2'd1:    buf_d[7:0]   = bus.mem_rdata;
          2'd2:    buf_d[15:8]  = bus.mem_rdata;
          2'd3:    buf_d[23:16] = bus.mem_rdata;
          default: ;
        endcase
        if (cnt_q == 2'd3) begin
          state_d = S_LAST;
        end else begin
          cnt_d      = cnt_nxt;
          mem_re_d   = 1'b1;
          mem_addr_d = pc_q[AW-1:0] + AW'(cnt_nxt);
        end
      end
      S_LAST: begin
        inscode_d   = {bus.mem_rdata, buf_q};
        ins_pc_d    = pc_q;
        ins_valid_d = 1'b1;
        state_d     = S_VALID;
      end
      S_VALID: begin
        ins_valid_d = 1'b1;
        if (bus.ins_ready) begin
          load_en = 1'b1;
          load_pc = pc_q + 32'd4;
        end
      end
      S_ERR: ;
      default: state_d = S_IDLE;
    endcase

    // A redirect overrides both the sequential advance and any fetch that
    // is partly done. Stale read data that arrives afterwards lands in
    // cnt 0, where nothing is captured.
    if (bus.br_taken && (state_q != S_ERR)) begin
      load_en = 1'b1;
      load_pc = bus.br_target;
    end

    if (load_en) begin
      pc_d        = load_pc;
      cnt_d       = 2'd0;
      ins_valid_d = 1'b0;
      if (pc_legal(load_pc)) begin
        state_d    = S_RD;
        mem_re_d   = 1'b1;
        mem_addr_d = load_pc[AW-1:0];
      end else begin
        state_d     = S_ERR;
        mem_re_d    = 1'b0;
        fetch_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      pc_q        <= RESET_PC;
      buf_q       <= 24'd0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      ins_valid_q <= 1'b0;
      inscode_q   <= 32'd0;
      ins_pc_q    <= 32'd0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      buf_q       <= buf_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      ins_valid_q <= ins_valid_d;
      inscode_q   <= inscode_d;
      ins_pc_q    <= ins_pc_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign bus.mem_re    = mem_re_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.ins_valid = ins_valid_q;
  assign bus.inscode   = inscode_q;
  assign bus.ins_pc    = ins_pc_q;
  assign bus.fetch_err = fetch_err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;
  logic [7:0] mem [32];
  int         checks;
  int         failures;

  fetch_if #(.AW(5)) bus ();

  fetch_ctrl #(.RESET_PC(32'd0), .MEM_DEPTH(32), .AW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous 1-cycle-read memory holding bytes 0x00..0x1F
  always @(posedge clk) begin
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ins_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.mem_re !== 1'b0 || bus.mem_addr !== 5'd0 || bus.ins_valid !== 1'b0 ||
        bus.inscode !== 32'd0 || bus.ins_pc !== 32'd0 || bus.fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got re=%b addr=%0d v=%b code=%h pc=%h err=%b exp all zero",
               bus.mem_re, bus.mem_addr, bus.ins_valid, bus.inscode, bus.ins_pc, bus.fetch_err);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: got %0d exp 0", dbg_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_fetch();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (k <= 4) begin
        if (bus.mem_re !== 1'b1 || bus.mem_addr !== 5'(k - 1)) begin
          failures++;
          $display("FAIL first_fetch_addr k=%0d: got re=%b addr=%0d exp re=1 addr=%0d",
                   k, bus.mem_re, bus.mem_addr, k - 1);
        end
      end else if (bus.mem_re !== 1'b0) begin
        failures++;
        $display("FAIL first_fetch_re k=%0d: got %b exp 0", k, bus.mem_re);
      end
      checks++;
      if (bus.ins_valid !== (k == 6)) begin
        failures++;
        $display("FAIL first_fetch_valid k=%0d: got %b exp %b", k, bus.ins_valid, (k == 6));
      end
    end
    checks++;
    if (bus.inscode !== 32'h03020100 || bus.ins_pc !== 32'd0) begin
      failures++;
      $display("FAIL first_fetch_word: got %h@%h exp 03020100@00000000", bus.inscode, bus.ins_pc);
    end
  endtask

  task automatic test_sequential();
    bit ok;
    wait_valid(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL seq_timeout: got no ins_valid exp ins_valid within 20 cycles");
    end
    checks++;
    if (bus.inscode !== 32'h07060504 || bus.ins_pc !== 32'd4) begin
      failures++;
      $display("FAIL seq_word: got %h@%h exp 07060504@00000004", bus.inscode, bus.ins_pc);
    end
  endtask

  task automatic test_stall();
    bit ok;
    bus.ins_ready = 1'b0;
    do_reset();
    wait_valid(ok);
    checks++;
    if (!ok || bus.inscode !== 32'h03020100 || bus.ins_pc !== 32'd0) begin
      failures++;
      $display("FAIL stall_first: got ok=%b %h@%h exp 03020100@00000000", ok, bus.inscode, bus.ins_pc);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.ins_valid !== 1'b1 || bus.inscode !== 32'h03020100 ||
          bus.ins_pc !== 32'd0 || bus.mem_re !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold i=%0d: got v=%b %h@%h re=%b exp v=1 03020100@0 re=0",
                 i, bus.ins_valid, bus.inscode, bus.ins_pc, bus.mem_re);
      end
    end
    bus.ins_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_re !== 1'b1 || bus.mem_addr !== 5'd4 || bus.ins_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: got re=%b addr=%0d v=%b exp re=1 addr=4 v=0",
               bus.mem_re, bus.mem_addr, bus.ins_valid);
    end
    wait_valid(ok);
    checks++;
    if (!ok || bus.inscode !== 32'h07060504 || bus.ins_pc !== 32'd4) begin
      failures++;
      $display("FAIL stall_next: got ok=%b %h@%h exp 07060504@00000004", ok, bus.inscode, bus.ins_pc);
    end
  endtask

  task automatic test_branch_mid_rd();
    bit ok;
    bus.ins_ready = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);   // now in RD with cnt = 2
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h10;
    @(negedge clk);
    bus.br_taken = 1'b0;
    checks++;
    if (bus.mem_re !== 1'b1 || bus.mem_addr !== 5'h10 || bus.ins_valid !== 1'b0) begin
      failures++;
      $display("FAIL br_rd_addr: got re=%b addr=%h v=%b exp re=1 addr=10 v=0",
               bus.mem_re, bus.mem_addr, bus.ins_valid);
    end
    wait_valid(ok);
    checks++;
    if (!ok || bus.inscode !== 32'h13121110 || bus.ins_pc !== 32'h10) begin
      failures++;
      $display("FAIL br_rd_word: got ok=%b %h@%h exp 13121110@00000010", ok, bus.inscode, bus.ins_pc);
    end
  endtask

  task automatic test_branch_drop();
    bit ok;
    bus.ins_ready = 1'b0;
    do_reset();
    wait_valid(ok);
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h08;
    @(negedge clk);
    bus.br_taken = 1'b0;
    checks++;
    if (bus.ins_valid !== 1'b0 || bus.mem_re !== 1'b1 || bus.mem_addr !== 5'h08) begin
      failures++;
      $display("FAIL br_drop_addr: got v=%b re=%b addr=%h exp v=0 re=1 addr=08",
               bus.ins_valid, bus.mem_re, bus.mem_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok || bus.inscode !== 32'h0B0A0908 || bus.ins_pc !== 32'h08) begin
      failures++;
      $display("FAIL br_drop_word: got ok=%b %h@%h exp 0b0a0908@00000008", ok, bus.inscode, bus.ins_pc);
    end
  endtask

  task automatic test_branch_handshake();
    bit ok;
    bus.ins_ready = 1'b1;
    do_reset();
    wait_valid(ok);
    wait_valid(ok);
    checks++;
    if (!ok || bus.ins_pc !== 32'd4) begin
      failures++;
      $display("FAIL br_hs_pre: got ok=%b pc=%h exp pc=00000004", ok, bus.ins_pc);
    end
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h0C;
    @(negedge clk);
    bus.br_taken = 1'b0;
    checks++;
    if (bus.mem_re !== 1'b1 || bus.mem_addr !== 5'h0C) begin
      failures++;
      $display("FAIL br_hs_addr: got re=%b addr=%h exp re=1 addr=0c", bus.mem_re, bus.mem_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok || bus.inscode !== 32'h0F0E0D0C || bus.ins_pc !== 32'h0C) begin
      failures++;
      $display("FAIL br_hs_word: got ok=%b %h@%h exp 0f0e0d0c@0000000c", ok, bus.inscode, bus.ins_pc);
    end
  endtask

  task automatic test_err_misaligned();
    bus.ins_ready = 1'b1;
    do_reset();
    @(negedge clk);
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h06;
    @(negedge clk);
    bus.br_target = 32'h00;      // must be ignored while in ERR
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.fetch_err !== 1'b1 || bus.ins_valid !== 1'b0 || bus.mem_re !== 1'b0 ||
          dbg_state !== 3'd4) begin
        failures++;
        $display("FAIL err_misaligned i=%0d: got err=%b v=%b re=%b st=%0d exp err=1 v=0 re=0 st=4",
                 i, bus.fetch_err, bus.ins_valid, bus.mem_re, dbg_state);
      end
      @(negedge clk);
      if (i == 1) bus.br_taken = 1'b0;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: got %b exp 0", bus.fetch_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_err_sequential();
    bit ok;
    bus.ins_ready = 1'b1;
    do_reset();
    bus.br_taken  = 1'b1;
    bus.br_target = 32'h1C;
    @(negedge clk);
    bus.br_taken = 1'b0;
    checks++;
    if (bus.mem_re !== 1'b1 || bus.mem_addr !== 5'h1C) begin
      failures++;
      $display("FAIL err_seq_addr: got re=%b addr=%h exp re=1 addr=1c", bus.mem_re, bus.mem_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok || bus.inscode !== 32'h1F1E1D1C || bus.ins_pc !== 32'h1C) begin
      failures++;
      $display("FAIL err_seq_word: got ok=%b %h@%h exp 1f1e1d1c@0000001c", ok, bus.inscode, bus.ins_pc);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.fetch_err !== 1'b1 || bus.ins_valid !== 1'b0 || bus.mem_re !== 1'b0) begin
        failures++;
        $display("FAIL err_seq i=%0d: got err=%b v=%b re=%b exp err=1 v=0 re=0",
                 i, bus.fetch_err, bus.ins_valid, bus.mem_re);
      end
    end
    do_reset();
    checks++;
    if (bus.fetch_err !== 1'b0 || dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL err_seq_reset: got err=%b st=%0d exp err=0 st=0", bus.fetch_err, dbg_state);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    bus.ins_ready = 1'b1;
    do_reset();
    wait_valid(ok);
    repeat (2) @(negedge clk);   // second fetch, RD with cnt = 1
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_re !== 1'b0 || bus.mem_addr !== 5'd0 || bus.ins_valid !== 1'b0 ||
        bus.inscode !== 32'd0 || bus.ins_pc !== 32'd0 || bus.fetch_err !== 1'b0 ||
        dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL async_reset: got re=%b addr=%0d v=%b code=%h pc=%h err=%b st=%0d exp all zero",
               bus.mem_re, bus.mem_addr, bus.ins_valid, bus.inscode, bus.ins_pc,
               bus.fetch_err, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_re !== 1'b1 || bus.mem_addr !== 5'd0) begin
      failures++;
      $display("FAIL async_restart_addr: got re=%b addr=%0d exp re=1 addr=0", bus.mem_re, bus.mem_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok || bus.inscode !== 32'h03020100 || bus.ins_pc !== 32'd0) begin
      failures++;
      $display("FAIL async_restart_word: got ok=%b %h@%h exp 03020100@00000000",
               ok, bus.inscode, bus.ins_pc);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.ins_ready = 1'b1;
    bus.br_taken  = 1'b0;
    bus.br_target = 32'd0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);

    test_reset();
    test_first_fetch();
    test_sequential();
    test_stall();
    test_branch_mid_rd();
    test_branch_drop();
    test_branch_handshake();
    test_err_misaligned();
    test_err_sequential();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences instruction fetch from the byte-wide instruction memory and assembles a 32-bit little-endian instruction word, four bytes per fetch.
- Owns the program counter, advances it on decode handshake, and accepts branch redirects from execute.
- Sits between the instruction memory (single-port, synchronous 1-cycle read) and decode.

Parameters:
- RESET_PC, 0, PC value after reset; must be word-aligned and <= MEM_DEPTH-4.
- MEM_DEPTH, 32, instruction memory size in bytes.
- AW, 5, memory address width; clog2(MEM_DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- mem_re  out  1  memory read enable.
- mem_addr  out  AW  byte address for the read.
- mem_rdata  in  8  read data, valid the cycle after mem_re.
- br_taken  in  1  redirect request, single-cycle pulse.
- br_target  in  32  redirect PC.
- ins_ready  in  1  decode accepts the instruction.
- ins_valid  out  1  inscode/ins_pc valid.
- inscode  out  32  assembled instruction {b3,b2,b1,b0}.
- ins_pc  out  32  PC of inscode.
- fetch_err  out  1  sticky error flag.

Behaviour:
- Reset is asynchronous and active-high; one clock domain, clk.
- Reset values:
  - state = IDLE, pc = RESET_PC, cnt = 0.
  - mem_re = 0, mem_addr = 0.
  - ins_valid = 0, inscode = 0, ins_pc = 0, fetch_err = 0.
- A reset asserted mid-fetch aborts the fetch immediately.
- States: IDLE, RD, LAST, VALID, ERR.
- IDLE: goes to RD with cnt = 0 on the next edge, unconditionally.
- RD:
  - mem_re = 1 and mem_addr = pc[AW-1:0] + cnt.
  - When cnt >= 1, mem_rdata is captured into byte lane cnt-1.
  - cnt increments each cycle; cnt == 3 goes to LAST.
- LAST:
  - mem_re = 0; captures mem_rdata into byte lane 3.
  - Next state is VALID; ins_pc = pc.
- VALID:
  - ins_valid = 1; inscode and ins_pc are held stable until ins_ready = 1.
  - On handshake, pc <= pc + 4 and the next state is RD with cnt = 0.
- mem_re is low in IDLE, LAST, VALID and ERR.
- Latency: RD (cnt 0) is entered at cycle t; ins_valid rises at t+5.
- Throughput: one instruction per 6 cycles when ins_ready is held high.
- Byte k of inscode comes from address pc+k, so inscode[8k+7:8k] = Mem[pc+k].
- Branch redirect (highest priority, active in IDLE, RD, LAST and VALID):
  - pc <= br_target, cnt <= 0, next state is RD.
  - Any partial capture is discarded; the read data returned the cycle after the abort is ignored.
  - ins_valid is 0 the cycle after the redirect.
  - br_taken in VALID together with ins_ready = 1 counts as a handshake; the next pc is br_target, not pc+4.
  - br_taken in VALID with ins_ready = 0 drops the held instruction.
- PC legality check, applied on every pc load (branch or increment):
  - Illegal when new_pc[1:0] != 0, or new_pc > MEM_DEPTH-4 (unsigned, full 32 bits).
  - An illegal load goes to ERR: fetch_err = 1, pc keeps the offending value, ins_valid = 0, mem_re = 0.
  - ERR is left only by reset; br_taken is ignored in ERR.
- Address arithmetic: pc + cnt never exceeds MEM_DEPTH-1 because of the legality check, so there is no wrap; pc + 4 is computed in 32 bits.

Test Plan:
- Memory loaded with bytes 0x00..0x1F; release reset with ins_ready = 1:
  - mem_addr sequence 0,1,2,3; ins_valid at cycle 6 after reset release with inscode = 0x03020100 and ins_pc = 0.
  - Next instruction is inscode = 0x07060504, ins_pc = 4.
- Hold ins_ready = 0 for 10 cycles in VALID:
  - inscode/ins_pc stable and mem_re = 0 throughout.
  - Raising ins_ready gives the next fetch at pc = 4 with mem_re the following cycle.
- br_taken with br_target = 0x10 during RD cnt = 2:
  - Next mem_addr = 0x10; result inscode = 0x13121110, ins_pc = 0x10.
  - No partial bytes from the aborted fetch appear.
- br_taken with br_target = 0x0C coincident with a VALID handshake at pc = 4: next ins_pc = 0x0C, not 8.
- br_target = 0x06, and separately sequential advance from pc = 0x1C:
  - fetch_err = 1 and ins_valid = 0 permanently; only rst clears them.
- Assert rst asynchronously mid-RD: all outputs return to reset values without a clock edge; the fetch restarts at RESET_PC.
